// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage in front of the unified 256x16 memory.
// It owns the PC, sequences READ/PUSH on the instruction side of the memory,
// yields the memory to the data stage, and queues fetched words for decode.
// Build macro FETCH_QUEUE_EN: 2-entry fetch queue with back-to-back fetches;
// when undefined, a single holding register is used.
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        i_read,
    output logic        i_push,
    output logic [15:0] i_addr,
    input  logic [15:0] d_bus,
    input  logic        dmem_req,
    output logic        dmem_gnt,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic [15:0] instr,
    output logic [15:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready
);

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 16;
`ifdef FETCH_QUEUE_EN
    localparam int unsigned DEPTH = 2;
`else
    localparam int unsigned DEPTH = 1;
`endif
    localparam int unsigned OCC_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        PUSH = 2'd2
    } state_t;

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [DW-1:0] word;
    } q_entry_t;

    state_t           state;
    logic [AW-1:0]    pc;
    logic [OCC_W-1:0] occ;
    logic [OCC_W-1:0] next_occ;
    logic             pop;
    logic             cap;
    logic             room;

    // Queue bookkeeping shared by the FSM and the queue storage
    assign pop      = instr_valid & instr_ready;
    assign cap      = (state == PUSH) & ~redirect;
    assign next_occ = occ + OCC_W'(cap) - OCC_W'(pop);
    assign room     = (next_occ < OCC_W'(DEPTH));

    assign i_addr   = pc;
    assign dmem_gnt = dmem_req & (state == IDLE);

    // Fetch sequencer and PC; i_read/i_push are registered copies of the next state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            i_read <= 1'b0;
            i_push <= 1'b0;
            pc     <= RESET_PC;
        end else if (redirect) begin
            state  <= IDLE;
            i_read <= 1'b0;
            i_push <= 1'b0;
            pc     <= redirect_pc;
        end else begin
            case (state)
                IDLE: begin
                    if (!dmem_req && room) begin
                        state  <= READ;
                        i_read <= 1'b1;
                        i_push <= 1'b0;
                    end else begin
                        state  <= IDLE;
                        i_read <= 1'b0;
                        i_push <= 1'b0;
                    end
                end
                READ: begin
                    state  <= PUSH;
                    i_read <= 1'b0;
                    i_push <= 1'b1;
                end
                PUSH: begin
                    pc <= pc + AW'(1);
                    if (!dmem_req && room) begin
                        state  <= READ;
                        i_read <= 1'b1;
                        i_push <= 1'b0;
                    end else begin
                        state  <= IDLE;
                        i_read <= 1'b0;
                        i_push <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    i_read <= 1'b0;
                    i_push <= 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_QUEUE_EN
    q_entry_t q_mem [DEPTH];
    logic     head;
    logic     tail;

    // Two-entry FIFO: write at tail on capture, advance head on decode accept
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_mem[0]    <= '0;
            q_mem[1]    <= '0;
            head        <= 1'b0;
            tail        <= 1'b0;
            occ         <= '0;
            instr_valid <= 1'b0;
        end else if (redirect) begin
            head        <= 1'b0;
            tail        <= 1'b0;
            occ         <= '0;
            instr_valid <= 1'b0;
        end else begin
            if (cap) begin
                q_mem[tail].pc   <= pc;
                q_mem[tail].word <= d_bus;
                tail             <= ~tail;
            end
            if (pop) begin
                head <= ~head;
            end
            occ         <= next_occ;
            instr_valid <= (next_occ != '0);
        end
    end

    assign instr    = q_mem[head].word;
    assign instr_pc = q_mem[head].pc;
`else
    q_entry_t q_head;

    // Single holding register: loaded on capture, emptied by decode accept
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_head      <= '0;
            occ         <= '0;
            instr_valid <= 1'b0;
        end else if (redirect) begin
            occ         <= '0;
            instr_valid <= 1'b0;
        end else begin
            if (cap) begin
                q_head.pc   <= pc;
                q_head.word <= d_bus;
            end
            occ         <= next_occ;
            instr_valid <= (next_occ != '0);
        end
    end

    assign instr    = q_head.word;
    assign instr_pc = q_head.pc;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit with a 256x16 memory model
// and a minimal data-stage model sharing d_bus.
module tb_fetch_unit;

    localparam logic [15:0] RST_PC = 16'h0000;
`ifdef FETCH_QUEUE_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif
    localparam int STEP = (DEPTH == 1) ? 3 : 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_read;
    logic        i_push;
    logic [15:0] i_addr;
    logic [15:0] d_bus;
    logic        dmem_req = 1'b0;
    logic        dmem_gnt;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready = 1'b1;

    logic [15:0] mem [256];
    logic [15:0] istore;
    logic [15:0] dstore;
    logic        d_push;
    int          cyc;

    int          n_vec = 0;
    int          n_err = 0;
    int          n_pops = 0;
    logic [31:0] sb [$];
    int          pop_cyc [$];
    bit          rec_en = 1'b0;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RST_PC)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_read      (i_read),
        .i_push      (i_push),
        .i_addr      (i_addr),
        .d_bus       (d_bus),
        .dmem_req    (dmem_req),
        .dmem_gnt    (dmem_gnt),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected fetch stream starting at a given PC: {pc, word}
    function automatic void seed(input logic [15:0] t);
        logic [15:0] a;
        for (int i = 0; i < 16; i++) begin
            a = t + 16'(i);
            sb.push_back({a, mem[a[7:0]]});
        end
    endfunction

    // Memory and data-stage model; cycle counter is the cycle index of the next period
    always @(posedge clk) begin
        if (i_read) istore <= mem[i_addr[7:0]];
        if (!rst_n) begin
            d_push <= 1'b0;
            cyc    <= 0;
        end else begin
            if (dmem_req && dmem_gnt) dstore <= mem[8'hF0];
            d_push <= dmem_req && dmem_gnt;
            cyc    <= cyc + 1;
        end
    end

    assign d_bus = i_push ? istore : (d_push ? dstore : 16'h0000);

    // Scoreboard: seed on reset/redirect, compare each accepted instruction
    always @(negedge clk) begin
        logic [31:0] e;
        if (!rst_n) begin
            sb.delete();
            seed(RST_PC);
        end else begin
            if (d_push) check_eq("bus_excl", 32'(i_push), 32'd0);
            if (instr_valid && instr_ready) begin
                n_pops++;
                if (rec_en) pop_cyc.push_back(cyc);
                check_eq("sb_nonempty", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check_eq("instr", {instr_pc, instr}, e);
                end
            end
            if (redirect) begin
                sb.delete();
                seed(redirect_pc);
            end
        end
    end

    task automatic wait_pops(input int n, input int budget, input string tag);
        int target;
        target = n_pops + n;
        for (int i = 0; i < budget; i++) begin
            if (n_pops >= target) break;
            @(negedge clk);
            #1;
        end
        check_eq(tag, 32'(n_pops >= target), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_read"},  32'(i_read), 32'd0);
        check_eq({tag, "_push"},  32'(i_push), 32'd0);
        check_eq({tag, "_valid"}, 32'(instr_valid), 32'd0);
        check_eq({tag, "_instr"}, {instr_pc, instr}, 32'd0);
        check_eq({tag, "_addr"},  32'(i_addr), 32'(RST_PC));
    endtask

    initial begin
        int nrd;
        for (int i = 0; i < 256; i++) mem[i] = 16'(i * 263 + 16'h1234);

        // Reset state and basic fetch stream timing
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        rec_en = 1'b1;
        rst_n  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_eq("c1_read", 32'(i_read), 32'd1);
        check_eq("c1_addr", 32'(i_addr), 32'(RST_PC));
        @(negedge clk);
        check_eq("c2_push", 32'(i_push), 32'd1);
        wait_pops(4, 40, "t1_pops");
        rec_en = 1'b0;
        check_eq("t1_ncyc", 32'(pop_cyc.size() >= 3), 32'd1);
        if (pop_cyc.size() >= 3) begin
            for (int k = 0; k < 3; k++) check_eq("t1_cyc", 32'(pop_cyc[k]), 32'(3 + k * STEP));
        end

        // Back-pressure: head holds, at most DEPTH fetches issued
        @(posedge clk); #1;
        rst_n = 1'b0;
        instr_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        nrd = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i_read) nrd++;
            if (instr_valid) break;
        end
        check_eq("t2_valid", 32'(instr_valid), 32'd1);
        repeat (10) begin
            @(negedge clk);
            if (i_read) nrd++;
            check_eq("t2_hold", {instr_pc, instr}, {RST_PC, mem[RST_PC[7:0]]});
        end
        check_eq("t2_nread", 32'(nrd), 32'(DEPTH));
        @(posedge clk); #1;
        instr_ready = 1'b1;
        wait_pops(3, 30, "t2_pops");

        // Redirect during READ
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (i_read) break;
        end
        check_eq("t3_inread", 32'(i_read), 32'd1);
        redirect_pc = 16'h0020;
        redirect    = 1'b1;
        @(posedge clk); #1;
        redirect = 1'b0;
        @(negedge clk);
        check_eq("t3_flush", 32'(instr_valid), 32'd0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (i_read) break;
        end
        check_eq("t3_reread", {15'd0, i_read, i_addr}, {15'd0, 1'b1, 16'h0020});
        wait_pops(3, 30, "t3_pops");

        // Redirect during PUSH
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (i_push) break;
        end
        check_eq("t3b_inpush", 32'(i_push), 32'd1);
        redirect_pc = 16'h0020;
        redirect    = 1'b1;
        @(posedge clk); #1;
        redirect = 1'b0;
        @(negedge clk);
        check_eq("t3b_flush", 32'(instr_valid), 32'd0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (i_read) break;
        end
        check_eq("t3b_reread", {15'd0, i_read, i_addr}, {15'd0, 1'b1, 16'h0020});
        wait_pops(3, 30, "t3b_pops");

        // Data stage request raised while in PUSH
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (i_push) break;
        end
        check_eq("t4_inpush", 32'(i_push), 32'd1);
        dmem_req = 1'b1;
        @(posedge clk); #1;
        check_eq("t4_gnt", 32'(dmem_gnt), 32'd1);
        check_eq("t4_idle", {30'd0, i_read, i_push}, 32'd0);
        nrd = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (i_read) nrd++;
        end
        check_eq("t4_noread", 32'(nrd), 32'd0);
        dmem_req = 1'b0;
        @(posedge clk); #1;
        check_eq("t4_resume", 32'(i_read), 32'd1);
        wait_pops(3, 30, "t4_pops");

        // PC wrap from 16'hFFFF
        @(posedge clk); #1;
        redirect_pc = 16'hFFFF;
        redirect    = 1'b1;
        @(posedge clk); #1;
        redirect = 1'b0;
        wait_pops(3, 30, "t5_pops");

        // Reset asserted during PUSH that fills the queue
        @(posedge clk); #1;
        instr_ready = 1'b0;
        redirect_pc = 16'h0040;
        redirect    = 1'b1;
        @(posedge clk); #1;
        redirect = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (i_push && (DEPTH == 1 || instr_valid)) break;
        end
        check_eq("t6_inpush", 32'(i_push), 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_reset_outputs("t6");
        rst_n = 1'b1;
        instr_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_eq("t6_c1", {15'd0, i_read, i_addr}, {15'd0, 1'b1, RST_PC});
        wait_pops(2, 30, "t6_pops");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage that sits directly upstream of the unified 256x16 memory and feeds the decoder. It owns the program counter and drives the memory's instruction-side controls: `i_read` and `i_addr`, then `i_push` one cycle later. It captures the instruction word from the shared `d_bus` and presents it to decode through a valid/ready handshake. It also arbitrates the memory against the data stage and handles branch redirects.

## Interface
- `RESET_PC`, 16'h0000, PC value loaded on reset.
- `clk  input  1`: rising-edge clock, shared with memory.
- `rst_n  input  1`: synchronous, active-low reset.
- `i_read  output  1`: memory latches `mem[i_addr]` into its instruction store at the next edge.
- `i_push  output  1`: memory drives its instruction store onto `d_bus` this cycle.
- `i_addr  output  16`: fetch word address.
- `d_bus  input  16`: shared memory data bus; sampled only in PUSH.
- `dmem_req  input  1`: data stage wants the memory; held high for its whole read/push or write sequence.
- `dmem_gnt  output  1`: combinational, `dmem_req & (state==IDLE)`.
- `redirect  input  1`: one-cycle pulse; load new PC and flush.
- `redirect_pc  input  16`: target of the redirect.
- `instr  output  16`: instruction at the head of the queue.
- `instr_pc  output  16`: address `instr` was fetched from.
- `instr_valid  output  1`: `instr` and `instr_pc` are valid.
- `instr_ready  input  1`: decode accepts the head entry at this edge when `instr_valid` is high.

## Operation
- Moore FSM with three states: IDLE, READ and PUSH.
  - `i_read` = (state==READ).
  - `i_push` = (state==PUSH).
  - `i_addr` = `pc` while in READ or PUSH, otherwise don't-care (drive `pc`).
- Queue depth D is 1, or 2 with the macro. The queue stores {instr, instr_pc}.
  - pop = `instr_valid & instr_ready`.
  - cap = (state==PUSH) & !redirect.
  - next_occ = occ + cap − pop.
- IDLE → READ when !`dmem_req` & !`redirect` & next_occ < D. Otherwise stay in IDLE.
- READ → PUSH unconditionally, unless `redirect` is high.
- PUSH → READ when !`dmem_req` & next_occ < D. Otherwise PUSH → IDLE.
- On the PUSH edge:
  - `d_bus` is written to the queue tail with `instr_pc` = `pc`.
  - `pc` <= `pc` + 1, modulo 2^16, so 16'hFFFF wraps to 16'h0000.
- `dmem_req` blocks only new READs. An in-flight READ/PUSH always completes, so `i_push` and the data stage's `d_push` are never high together. The data stage must start only while `dmem_gnt` is high.
- Redirect has the highest priority. At the edge where `redirect` is high:
  - `pc` <= `redirect_pc`.
  - The queue is flushed (occ = 0).
  - The state goes to IDLE, and any in-flight fetch is discarded.
  - A simultaneous pop is still counted as accepted by decode.
- Reset values: `pc`=`RESET_PC`, state=IDLE, occ=0, `i_read`=0, `i_push`=0, `instr_valid`=0. `instr` and `instr_pc` are 0.
- Reset asserted mid-fetch abandons the fetch. No memory contents are affected.

## Timing
- Cycle 0 is the first edge with `rst_n`=1.
- Fetch sequence from reset:
  - `i_read` is high in cycle 1 with `i_addr`=`RESET_PC`.
  - `i_push` is high in cycle 2.
  - `instr_valid` is high from cycle 3.
- Fetch-to-valid latency is 2 cycles from the start of READ.
- Sustained throughput with `instr_ready` held high:
  - D=1: one instruction per 3 cycles (READ, PUSH, IDLE).
  - D=2: one instruction per 2 cycles.
- `instr_valid` falls only after a pop that empties the queue, a redirect, or reset. The head entry is stable while `instr_valid` & !`instr_ready`.
- First READ after a redirect: the cycle after the redirect edge, if no `dmem_req`.

## Configuration
- `FETCH_QUEUE_EN` defined: D=2. The queue is a 2-entry FIFO with head/tail pointers and PUSH can chain straight into READ.
- Not defined: D=1, a single holding register.
- Port list and reset behaviour are identical in both builds.

## Test plan
- Reset with memory words 0..3 = A,B,C,D, `instr_ready`=1:
  - `instr` sequence is A@0, B@1, C@2, D@3.
  - Valid at cycles 3, 6, 9 when D=1; at cycles 3, 5, 7 when D=2.
- `instr_ready`=0 for 10 cycles after the first valid:
  - `instr` holds A@0 and no further `i_read` beyond D entries.
  - Releasing ready yields B@1 next, with no skipped PC.
- `redirect` pulse with `redirect_pc`=16'h0020, timed once during READ and once during PUSH:
  - `instr_valid`=0 the next cycle and the fetched word is discarded.
  - `i_read` reappears with `i_addr`=16'h0020 and the next `instr_pc`=16'h0020.
- `dmem_req` raised while in PUSH:
  - The fetch completes and the state goes to IDLE with `dmem_gnt`=1.
  - No `i_read` while `dmem_req`=1; fetch resumes the cycle after `dmem_req` falls.
  - `i_push` is never high in a cycle the data stage pushes.
- `RESET_PC`=16'hFFFF: the sequence gives `instr_pc` 16'hFFFF, then 16'h0000.
- `rst_n`=0 asserted during PUSH with a full queue: at the next edge all outputs are at reset values and the fetch restarts from `RESET_PC`.
